// File: rtl/alu_share_arb_if.sv
// Request/response/ALU bundle for alu_share_arb. The arbiter uses the slave
// modport; the requesters plus the external ALU side use master.
interface alu_share_arb_if #(
    parameter int W = 32
);
    // Handshake rule for both req and resp: a transfer happens on the rising
    // edge where valid and ready are both high; the source holds valid and its
    // payload stable until that edge, and ready is never required before valid.
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic [2:0]   req_op0;
    logic [2:0]   req_op1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [W-1:0] resp_out;
    logic         resp_zero;
    logic         resp_err;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_out;
    logic         alu_zero;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        output req_ready,
        output resp_valid, resp_out, resp_zero, resp_err,
        input  resp_ready,
        output alu_in1, alu_in2, alu_op,
        input  alu_out, alu_zero
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        input  req_ready,
        input  resp_valid, resp_out, resp_zero, resp_err,
        output resp_ready,
        input  alu_in1, alu_in2, alu_op,
        output alu_out, alu_zero
    );
endinterface

// File: rtl/alu_share_arb.sv
// Time-shares one external combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_share_arb #(
    parameter int W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    alu_share_arb_if.slave   bus,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         illegal_q, illegal_d;
    logic [W-1:0] in1_q, in1_d;
    logic [W-1:0] in2_q, in2_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] out_q, out_d;
    logic         zero_q, zero_d;
    logic         err_q, err_d;

    logic         grant;
    logic [1:0]   ready;
    logic [W-1:0] win_a, win_b;
    logic [2:0]   win_op;
    logic         win_legal;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // No grant history in this build: port 0 simply wins every tie.
    always_comb begin
        grant = 1'b0;
        if (!bus.req_valid[0]) grant = bus.req_valid[1];
    end
`else
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant = 1'b0;
        if (&bus.req_valid) grant = ~last_grant_q;
        else                grant = bus.req_valid[1];
    end
`endif

    always_comb begin
        win_a     = grant ? bus.req_a1  : bus.req_a0;
        win_b     = grant ? bus.req_b1  : bus.req_b0;
        win_op    = grant ? bus.req_op1 : bus.req_op0;
        win_legal = (win_op == 3'b000) || (win_op == 3'b001) ||
                    (win_op == 3'b011) || (win_op == 3'b100);
        ready = 2'b00;
        // Gated by nRST so a request held across reset is never acknowledged.
        if (nRST && (state_q == IDLE) && (|bus.req_valid)) ready = grant ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        illegal_d = illegal_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        op_d      = op_q;
        out_d     = out_q;
        zero_d    = zero_q;
        err_d     = err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    owner_d   = grant;
                    illegal_d = !win_legal;
                    // An illegal op leaves the ALU inputs untouched.
                    if (win_legal) begin
                        in1_d = win_a;
                        in2_d = win_b;
                        op_d  = win_op;
                    end
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = grant;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                out_d   = illegal_q ? '0   : bus.alu_out;
                zero_d  = illegal_q ? 1'b1 : bus.alu_zero;
                err_d   = illegal_q;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            illegal_q <= 1'b0;
            in1_q     <= '0;
            in2_q     <= '0;
            op_q      <= 3'b000;
            out_q     <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            illegal_q <= illegal_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            op_q      <= op_d;
            out_q     <= out_d;
            zero_q    <= zero_d;
            err_q     <= err_d;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset to 1 so port 0 takes the first tie.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
`endif

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_out   = out_q;
    assign bus.resp_zero  = zero_q;
    assign bus.resp_err   = err_q;
    assign bus.alu_in1    = in1_q;
    assign bus.alu_in2    = in2_q;
    assign bus.alu_op     = op_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: per-port driver, behavioural ALU,
// expected-queue scoreboard drained by an independent response monitor.
module tb_alu_share_arb;
    localparam int W = 32;

    logic       CLK;
    logic       nRST;
    logic [1:0] dbg_state;
    logic       v0, v1;
    logic [1:0] resp_rdy;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;

    int total = 0;
    int bad   = 0;

    logic [W+2:0] exp_q[$];   // {port, err, zero, out}
    int           glog[$];    // accept order of ports

    logic [W-1:0] c_a0[4]  = '{32'd1, 32'h0000_00F0, 32'h0000_FF00, 32'd10};
    logic [W-1:0] c_b0[4]  = '{32'd2, 32'h0000_000F, 32'h0000_0FF0, 32'd3};
    logic [2:0]   c_op0[4] = '{3'b000, 3'b011, 3'b100, 3'b001};
    logic [W-1:0] c_r0[4]  = '{32'd3, 32'h0000_00FF, 32'h0000_0F00, 32'd7};
    logic [W-1:0] c_a1[4]  = '{32'd5, 32'd100, 32'h0000_AAAA, 32'd0};
    logic [W-1:0] c_b1[4]  = '{32'd6, 32'd200, 32'h0000_5555, 32'd0};
    logic [2:0]   c_op1[4] = '{3'b001, 3'b000, 3'b100, 3'b011};
    logic [W-1:0] c_r1[4]  = '{32'hFFFF_FFFF, 32'd300, 32'd0, 32'd0};

    alu_share_arb_if #(.W(W)) bus ();

    alu_share_arb #(.W(W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    assign bus.req_valid  = {v1, v0};
    assign bus.req_a0     = a0;
    assign bus.req_b0     = b0;
    assign bus.req_a1     = a1;
    assign bus.req_b1     = b1;
    assign bus.req_op0    = op0;
    assign bus.req_op1    = op1;
    assign bus.resp_ready = resp_rdy;

    // External ALU model
    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_out = bus.alu_in1 + bus.alu_in2;
            3'b001:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
            3'b011:  bus.alu_out = bus.alu_in1 | bus.alu_in2;
            3'b100:  bus.alu_out = bus.alu_in1 & bus.alu_in2;
            default: bus.alu_out = '0;
        endcase
        bus.alu_zero = (bus.alu_out == '0);
    end

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Driver: call at a falling edge; returns at the falling edge after the accept.
    task automatic drive(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [W-1:0] eo,
                         input logic ez, input logic ee);
        int n = 0;
        if (port == 0) begin a0 = a; b0 = b; op0 = op; v0 = 1'b1; end
        else           begin a1 = a; b1 = b; op1 = op; v1 = 1'b1; end
        #1;
        while (!bus.req_ready[port] && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (!bus.req_ready[port]) begin
            chk("req_ready_timeout", 64'(bus.req_ready), 64'(port == 0 ? 2'b01 : 2'b10));
            if (port == 0) v0 = 1'b0; else v1 = 1'b0;
            return;
        end
        exp_q.push_back({port[0], ee, ez, eo});
        glog.push_back(port);
        @(negedge CLK);
        if (port == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((dbg_state != 2'd0 || exp_q.size() != 0) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", 64'(dbg_state), 64'd0);
    endtask

    // Monitor: compares every completed response against the queue head.
    initial begin
        logic [W+2:0] e;
        forever begin
            @(negedge CLK);
            #3;
            if (nRST && ((bus.resp_valid & bus.resp_ready) != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_port", 64'(bus.resp_valid), 64'(e[W+2] ? 2'b10 : 2'b01));
                    chk("resp_out",  64'(bus.resp_out), 64'(e[W-1:0]));
                    chk("resp_zero", 64'(bus.resp_zero), 64'(e[W]));
                    chk("resp_err",  64'(bus.resp_err), 64'(e[W+1]));
                end
            end
        end
    end

    initial begin
        v0 = 0; v1 = 0; resp_rdy = 2'b11;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        nRST = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_req_ready",  64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_out",   64'(bus.resp_out), 64'd0);
        chk("rst_resp_zero",  64'(bus.resp_zero), 64'd0);
        chk("rst_resp_err",   64'(bus.resp_err), 64'd0);
        chk("rst_alu_in1",    64'(bus.alu_in1), 64'd0);
        chk("rst_alu_in2",    64'(bus.alu_in2), 64'd0);
        chk("rst_alu_op",     64'(bus.alu_op), 64'd0);
        chk("rst_state",      64'(dbg_state), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Single add with cycle-exact checks
        drive(0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0);
        #1;
        chk("t1_state_issue", 64'(dbg_state), 64'd1);
        chk("t1_alu_in1",     64'(bus.alu_in1), 64'd5);
        chk("t1_alu_in2",     64'(bus.alu_in2), 64'd7);
        chk("t1_alu_op",      64'(bus.alu_op), 64'd0);
        chk("t1_no_ready",    64'(bus.req_ready), 64'd0);
        chk("t1_no_valid",    64'(bus.resp_valid), 64'd0);
        @(negedge CLK);
        #1;
        chk("t1_resp_valid",  64'(bus.resp_valid), 64'b01);
        chk("t1_resp_out",    64'(bus.resp_out), 64'd12);
        wait_idle();

        // Sub to zero on port 1
        drive(1, 32'h1234, 32'h1234, 3'b001, 32'd0, 1'b1, 1'b0);
        wait_idle();

        // Contention
        glog.delete();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    drive(0, c_a0[i], c_b0[i], c_op0[i], c_r0[i], c_r0[i] == '0, 1'b0);
            end
            begin
                for (int i = 0; i < 4; i++)
                    drive(1, c_a1[i], c_b1[i], c_op1[i], c_r1[i], c_r1[i] == '0, 1'b0);
            end
        join
        wait_idle();
        chk("cont_grant_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < glog.size() && i < 8; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk($sformatf("cont_grant%0d", i), 64'(glog[i]), 64'(i >= 4));
`else
            chk($sformatf("cont_grant%0d", i), 64'(glog[i]), 64'(i % 2));
`endif
        end

        // Backpressure on port 0, port 1 request withdrawn before acceptance
        resp_rdy = 2'b10;
        drive(0, 32'd3, 32'd4, 3'b000, 32'd7, 1'b0, 1'b0);
        @(negedge CLK);
        a1 = 32'd50; b1 = 32'd60; op1 = 3'b000; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_resp_out",   64'(bus.resp_out), 64'd7);
            chk("bp_resp_valid", 64'(bus.resp_valid), 64'b01);
            chk("bp_no_ready",   64'(bus.req_ready), 64'd0);
            @(negedge CLK);
        end
        resp_rdy = 2'b11;
        v1 = 1'b0;
        @(negedge CLK);
        #1;
        chk("bp_idle_next", 64'(dbg_state), 64'd0);
        chk("bp_valid_low", 64'(bus.resp_valid), 64'd0);
        repeat (6) @(negedge CLK);

        // Illegal op keeps previous alu_op, then add wraps to zero
        drive(1, 32'd1, 32'd2, 3'b011, 32'd3, 1'b0, 1'b0);
        wait_idle();
        drive(0, 32'd9, 32'd9, 3'b110, 32'd0, 1'b1, 1'b1);
        #1;
        chk("ill_alu_op_held", 64'(bus.alu_op), 64'b011);
        wait_idle();
        drive(0, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 1'b1, 1'b0);
        wait_idle();

        // Asynchronous reset while in ISSUE
        drive(0, 32'd1, 32'd1, 3'b000, 32'd2, 1'b0, 1'b0);
        #2;
        nRST = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_state",      64'(dbg_state), 64'd0);
        chk("arst_alu_in1",    64'(bus.alu_in1), 64'd0);
        chk("arst_alu_op",     64'(bus.alu_op), 64'd0);
        chk("arst_resp_zero",  64'(bus.resp_zero), 64'd0);
        chk("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            #1;
            chk("arst_no_resp", 64'(bus.resp_valid), 64'd0);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
